// File: rtl/microwave_cook_controller.sv
// -----------------------------------------------------------------------------
// microwave_cook_controller
//   Top-level cook sequencer. Collects an M:SS cook time from the keypad,
//   loads it into the external countdown timer, paces that timer with a
//   once-per-second decrement strobe and drives the magnetron. It reacts to
//   the timer's done flag, the door sensor and the Start/Stop/Clear keys.
//
//   Optional feature macro: MWC_DONE_BEEP_EN
//     defined   -> on finishing, beep for BEEP_SECS seconds, then return to
//                  IDLE on its own (Stop/Clear/Start cut the beep short).
//     undefined -> beep is tied low and DONE is held until Stop/Clear/Start.
// -----------------------------------------------------------------------------
module microwave_cook_controller #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BEEP_SECS = 3
) (
    input  logic       CLK,
    input  logic       Reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       timer_done,
    output logic       timer_load,
    output logic       timer_enable,
    output logic [3:0] load_min_units,
    output logic [2:0] load_sec_tens,
    output logic [3:0] load_sec_units,
    output logic       mag_on,
    output logic       beep,
    output logic [2:0] state
);

    // Prescaler sizing: counts 0 .. TICK_DIV-1 within one cook second.
    localparam int            PW     = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SET_TIME = 3'd1,
        S_COOKING  = 3'd2,
        S_PAUSED   = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // Parameter sanity: the prescaler needs at least two states and the
    // beep needs at least one second.
    generate
        if (TICK_DIV < 2 || BEEP_SECS < 1) begin : g_param_check
            $error("microwave_cook_controller: need TICK_DIV >= 2 and BEEP_SECS >= 1");
        end
    endgenerate

    state_t        r_state;
    logic [3:0]    r_min_units;
    logic [2:0]    r_sec_tens;
    logic [3:0]    r_sec_units;
    logic [PW-1:0] r_presc;
    logic          r_timer_load;

`ifdef MWC_DONE_BEEP_EN
    localparam int            BEEP_CYC  = BEEP_SECS * TICK_DIV;
    localparam int            BW        = $clog2(BEEP_CYC);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYC - 1);

    logic          r_beep;
    logic [BW-1:0] r_beep_cnt;
`endif

    logic w_key_ok;
    logic w_entry_nz;
    logic w_cooking;
    logic w_run;
    logic w_tick;

    // A digit is accepted only if it is decimal and shifting the current
    // seconds-units digit into the seconds-tens slot keeps that slot 0-5.
    assign w_key_ok   = key_valid && (key_digit <= 4'd9) && (r_sec_units <= 4'd5);
    assign w_entry_nz = (r_min_units != 4'd0) || (r_sec_tens != 3'd0) ||
                        (r_sec_units != 4'd0);
    assign w_cooking  = (r_state == S_COOKING);

    // The second only advances while actually cooking and not leaving
    // COOKING this cycle, so a pause never swallows or repeats a decrement.
    assign w_run  = w_cooking && door_closed && !stop && !timer_done;
    assign w_tick = w_run && (r_presc == P_LAST);

    assign timer_enable   = w_tick;
    assign timer_load     = r_timer_load;
    assign load_min_units = r_min_units;
    assign load_sec_tens  = r_sec_tens;
    assign load_sec_units = r_sec_units;
    assign state          = r_state;

    // Door interlock: combinational so an opening door kills the magnetron
    // in the same cycle, and reset kills it without waiting for a clock.
    assign mag_on = w_cooking && door_closed;

`ifdef MWC_DONE_BEEP_EN
    assign beep = r_beep;
`else
    assign beep = 1'b0;
`endif

    // Cook sequencer: state, entered digits, second prescaler and load strobe.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= S_IDLE;
            r_min_units  <= 4'd0;
            r_sec_tens   <= 3'd0;
            r_sec_units  <= 4'd0;
            r_presc      <= '0;
            r_timer_load <= 1'b0;
`ifdef MWC_DONE_BEEP_EN
            r_beep       <= 1'b0;
            r_beep_cnt   <= '0;
`endif
        end else begin
            r_timer_load <= 1'b0;

            if (w_run) begin
                r_presc <= (r_presc == P_LAST) ? '0 : r_presc + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_key_ok) begin
                        r_min_units <= {1'b0, r_sec_tens};
                        r_sec_tens  <= r_sec_units[2:0];
                        r_sec_units <= key_digit;
                        r_state     <= S_SET_TIME;
                    end
                end

                S_SET_TIME: begin
                    if (clear) begin
                        r_min_units <= 4'd0;
                        r_sec_tens  <= 3'd0;
                        r_sec_units <= 4'd0;
                        r_presc     <= '0;
                        r_state     <= S_IDLE;
                    end else if (start && door_closed && w_entry_nz) begin
                        r_timer_load <= 1'b1;
                        r_presc      <= '0;
                        r_state      <= S_COOKING;
                    end else if (w_key_ok) begin
                        r_min_units <= {1'b0, r_sec_tens};
                        r_sec_tens  <= r_sec_units[2:0];
                        r_sec_units <= key_digit;
                    end
                end

                S_COOKING: begin
                    if (timer_done) begin
                        r_state <= S_DONE;
`ifdef MWC_DONE_BEEP_EN
                        r_beep     <= 1'b1;
                        r_beep_cnt <= '0;
`endif
                    end else if (!door_closed || stop) begin
                        // Prescaler is left untouched: the partial second
                        // resumes where it stopped.
                        r_state <= S_PAUSED;
                    end
                end

                S_PAUSED: begin
                    if (stop || clear) begin
                        r_min_units <= 4'd0;
                        r_sec_tens  <= 3'd0;
                        r_sec_units <= 4'd0;
                        r_presc     <= '0;
                        r_state     <= S_IDLE;
                    end else if (start && door_closed) begin
                        r_state <= S_COOKING;
                    end
                end

                S_DONE: begin
`ifdef MWC_DONE_BEEP_EN
                    if (stop || clear || start || (r_beep_cnt == BEEP_LAST)) begin
                        r_beep      <= 1'b0;
                        r_min_units <= 4'd0;
                        r_sec_tens  <= 3'd0;
                        r_sec_units <= 4'd0;
                        r_presc     <= '0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_beep_cnt <= r_beep_cnt + 1'b1;
                    end
`else
                    if (stop || clear || start) begin
                        r_min_units <= 4'd0;
                        r_sec_tens  <= 3'd0;
                        r_sec_units <= 4'd0;
                        r_presc     <= '0;
                        r_state     <= S_IDLE;
                    end
`endif
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
